// File: rtl/c3lib_dff_pipe_vld.sv
// c3lib_dff_pipe_vld
// WIDTH-bit register pipeline of DEPTH stages. Each stage carries a valid bit.
// Features: ready/valid backpressure, bubble collapsing, synchronous flush and
// occupancy reporting. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
module c3lib_dff_pipe_vld #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    localparam int                OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] data_in,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] data_out,
    input  logic             out_rdy,
    input  logic             flush,
    output logic [OCC_W-1:0] occ
);

    // Flattened views of the per-stage state, so that neighbouring stages
    // and the output logic can read them.
    logic [DEPTH-1:0] vld_vec;
    logic [WIDTH-1:0] dat_vec [DEPTH];

    // A stage may take a new word when it is empty, or when its successor moves
    // on this cycle. The chain ends at the downstream ready.
    logic [DEPTH-1:0] adv;

    // Build the advance chain from the output side back toward the input.
    always_comb begin
        logic carry;
        carry = out_rdy;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            carry  = ~vld_vec[i] | carry;
            adv[i] = carry;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             src_vld;
            logic [WIDTH-1:0] src_dat;
            logic             vld_reg;
            logic [WIDTH-1:0] dat_reg;

            if (gi == 0) begin : g_head
                assign src_vld = in_vld;
                assign src_dat = data_in;
            end else begin : g_body
                assign src_vld = vld_vec[gi-1];
                assign src_dat = dat_vec[gi-1];
            end

            // Stage register. Flush clears only the valid bit. Data loads only
            // when a real word arrives, so bubbles leave the data flops untouched.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_reg <= 1'b0;
                    dat_reg <= RESET_VAL;
                end else if (flush) begin
                    vld_reg <= 1'b0;
                end else if (adv[gi]) begin
                    vld_reg <= src_vld;
                    if (src_vld) begin
                        dat_reg <= src_dat;
                    end
                end
            end

            assign vld_vec[gi] = vld_reg;
            assign dat_vec[gi] = dat_reg;
        end
    endgenerate

    logic [OCC_W-1:0] occ_next;

    // Occupancy is the number of stages holding a valid word.
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + OCC_W'(vld_vec[i]);
        end
    end

    // Flush blocks capture, so a word offered during a flush is never taken.
    assign in_rdy   = adv[0] & ~flush;
    assign out_vld  = vld_vec[DEPTH-1];
    assign data_out = dat_vec[DEPTH-1];
    assign occ      = occ_next;

endmodule
